onchip_mem_fill_engine: RTL and testbench
=========================================

Name: onchip_mem_fill_engine

Overview:
Avalon-MM helper that owns the second port (s2) of the 102400x32 on-chip RAM feeding the Nios core. Under software control through a small CSR slave, it either fills a word range with a fixed or incrementing pattern, or reads the range back and counts mismatches against the same pattern. It is used for boot-time RAM init, memory test, and scrubbing without CPU load/store traffic.

Parameters:
ADDR_W, 17, memory word-address width (matches RAM port width)
DATA_W, 32, memory data width; CSR width is fixed at 32
DEPTH, 102400, number of valid RAM words; used for range checks

Ports:
clk  in  1  system clock, shared with the RAM
reset_n  in  1  synchronous, active-low reset
csr_address  in  3  CSR word offset
csr_read  in  1  CSR read strobe; readdata is valid on the next cycle (latency 1)
csr_write  in  1  CSR write strobe
csr_writedata  in  32  CSR write data
csr_readdata  out  32  CSR read data (registered)
mem_address  out  ADDR_W  RAM port-2 word address
mem_byteenable  out  4  always 4'hF
mem_chipselect  out  1  RAM port-2 select
mem_write  out  1  RAM port-2 write
mem_writedata  out  DATA_W  RAM port-2 write data
mem_readdata  in  DATA_W  RAM port-2 read data; valid the cycle after the address is presented
mem_clken  out  1  RAM port-2 clock enable; tied to 1

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: all outputs 0, except mem_byteenable=4'hF and mem_clken=1. State=IDLE. All CSRs 0.
- CSR map (word offsets):
  - 0 CTRL, write: bit0 START, bit1 MODE (0=fill, 1=check), bit2 INCR, bit3 ABORT.
  - 0 CTRL, read: bit0 BUSY, bit1 DONE, bit2 MISMATCH, bit3 RANGE_ERR, bit4 ABORTED.
  - 1 BASE: word address. 2 LENGTH: word count. 3 PATTERN.
  - 4 ERR_COUNT (read-only). 5 FIRST_ERR_ADDR (read-only).
  - 6 CLEAR: any write clears DONE, MISMATCH, RANGE_ERR and ABORTED.
  - Unmapped offsets read 0.
- Expected/write data for word i (0-based): PATTERN + (INCR ? i : 0), modulo 2^32.
- States: IDLE, FILL, CHECK, DRAIN.
- START accepted in IDLE:
  - Clears ERR_COUNT, FIRST_ERR_ADDR and the sticky flags.
  - LENGTH=0: DONE set next cycle, no RAM access.
  - BASE+LENGTH > DEPTH (evaluated with 33-bit arithmetic): RANGE_ERR and DONE set next cycle, no RAM access.
  - Otherwise: go to FILL or CHECK per MODE; BUSY=1 from the next cycle.
- FILL:
  - One write per cycle: chipselect=write=1, address=BASE+i.
  - Last word issued → IDLE, DONE=1.
  - Start strobe at cycle T → writes on T+1..T+N, DONE visible at T+N+1.
- CHECK:
  - One read per cycle: chipselect=1, write=0.
  - Word i's data is compared in the following cycle, with a 1-stage pipeline holding the expected value and address.
  - After the last address, go to DRAIN for one compare cycle, then IDLE with DONE=1 at T+N+2.
- Mismatch handling:
  - Increment ERR_COUNT, saturating at 32'hFFFFFFFF.
  - On the first mismatch only, latch FIRST_ERR_ADDR and set MISMATCH.
- START while BUSY: ignored.
- START and ABORT in the same write: ABORT wins.
- ABORT while busy:
  - No new access from the next cycle; state → IDLE.
  - ABORTED=1, DONE stays 0.
  - A compare already in flight is discarded.
- CSR writes to BASE, LENGTH or PATTERN while BUSY: ignored.
- Reset mid-operation: immediate return to reset values; a partially filled range is left as-is.
- Address never wraps: the range check guarantees BASE+i < DEPTH.

Optional Feature:
ONCHIP_FILL_IRQ_EN:
- Defined: adds output port irq (1 bit, reset 0).
  - irq = DONE | ABORTED, level-sensitive; cleared by a write to CLEAR.
  - CTRL bit5 is IRQ_ENABLE (R/W, reset 0) and gates irq.
- Undefined: no irq port; CTRL bit5 reads 0 and writes to it are ignored.

Decomposition:
- Package onchip_fill_pkg: state enum; CSR offset constants; CTRL/status bit-index constants; MODE_FILL/MODE_CHECK constants.
- One sub-module, onchip_fill_csr: register file, read mux, sticky-flag and clear logic.
- Sequencer, pattern generator and compare pipeline stay in the top module.

Test Plan:
- Fill: BASE=0x10, LENGTH=4, PATTERN=0xA5A50000, INCR=1 → words 0x10..0x13 = 0xA5A50000..0xA5A50003; 4 write cycles; DONE at T+5.
- Check, same settings → ERR_COUNT=0, MISMATCH=0; DONE at T+6.
- Corrupt word 0x12 via port 1, then check → ERR_COUNT=1, FIRST_ERR_ADDR=0x12, MISMATCH=1.
- LENGTH=0 → DONE next cycle, no chipselect ever asserted. BASE=102398, LENGTH=4 → RANGE_ERR=1, no access.
- Fill LENGTH=100, ABORT on 10th write cycle → exactly 10 words written (no further chipselect after the ABORT cycle), ABORTED=1, DONE=0, BUSY=0; later START runs normally.
- reset_n low for 1 cycle mid-check → all outputs at reset values the next cycle; CTRL reads 0.

Source files
------------

// File: rtl/onchip_fill_pkg.sv
// Shared types and constants for the on-chip RAM fill/check engine.
// State encoding, CSR offsets and CTRL/status bit positions.
package onchip_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  localparam logic [2:0] CSR_CTRL  = 3'd0;
  localparam logic [2:0] CSR_BASE  = 3'd1;
  localparam logic [2:0] CSR_LEN   = 3'd2;
  localparam logic [2:0] CSR_PAT   = 3'd3;
  localparam logic [2:0] CSR_ERRCNT = 3'd4;
  localparam logic [2:0] CSR_FIRST = 3'd5;
  localparam logic [2:0] CSR_CLEAR = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_INCR  = 2;
  localparam int CTRL_ABORT = 3;
  localparam int CTRL_IEN   = 5;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_MIS   = 2;
  localparam int STAT_RANGE = 3;
  localparam int STAT_ABRT  = 4;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

endpackage

// File: rtl/onchip_mem_fill_engine_if.sv
// CSR slave bus plus RAM port-2 master bus of the fill engine.
// slave: engine view; master: host/RAM view.
interface onchip_mem_fill_engine_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) ();
  logic [2:0]        csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_clken;

  modport slave (
    input  csr_address, csr_read, csr_write,
    input  csr_writedata, mem_readdata,
    output csr_readdata, mem_address,
    output mem_byteenable, mem_chipselect,
    output mem_write, mem_writedata, mem_clken
  );

  modport master (
    output csr_address, csr_read, csr_write,
    output csr_writedata, mem_readdata,
    input  csr_readdata, mem_address,
    input  mem_byteenable, mem_chipselect,
    input  mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_fill_csr.sv
// CSR file: config regs, result regs, sticky flags, registered read mux.
// Ports: csr bus in/readdata out, sequencer events in, decoded cmds out.
// Optional ONCHIP_FILL_IRQ_EN adds IRQ_ENABLE (CTRL bit5) and o_irq.
module onchip_fill_csr
  import onchip_fill_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_writedata,
  output logic [31:0]       o_readdata,
  input  logic              i_busy,
  input  logic              i_start_ok,
  input  logic              i_set_done,
  input  logic              i_set_range,
  input  logic              i_set_abort,
  input  logic              i_mis,
  input  logic [ADDR_W-1:0] i_mis_addr,
  output logic              o_start,
  output logic              o_abort,
  output logic              o_mode,
  output logic              o_incr,
  output logic [31:0]       o_base,
  output logic [31:0]       o_len,
  output logic [31:0]       o_pat
`ifdef ONCHIP_FILL_IRQ_EN
  ,
  output logic              o_irq
`endif
);

  logic [31:0] r_base;
  logic [31:0] r_len;
  logic [31:0] r_pat;
  logic [31:0] r_errcnt;
  logic [31:0] r_first;
  logic        r_done;
  logic        r_mis;
  logic        r_range;
  logic        r_aborted;
  logic [31:0] r_readdata;
  logic        w_ien;
  logic        w_ctrl_wr;
  logic        w_cfg_wr;
  logic        w_clear;
  logic [31:0] w_rdata;

  assign w_ctrl_wr = i_write && (i_address == CSR_CTRL);
  assign w_cfg_wr  = i_write && !i_busy;
  assign w_clear   = i_write && (i_address == CSR_CLEAR);

  // ABORT in the same write suppresses START
  assign o_abort = w_ctrl_wr && i_writedata[CTRL_ABORT];
  assign o_start = w_ctrl_wr && i_writedata[CTRL_START]
                 && !i_writedata[CTRL_ABORT];
  assign o_mode  = i_writedata[CTRL_MODE];
  assign o_incr  = i_writedata[CTRL_INCR];
  assign o_base  = r_base;
  assign o_len   = r_len;
  assign o_pat   = r_pat;
  assign o_readdata = r_readdata;

`ifdef ONCHIP_FILL_IRQ_EN
  logic r_ien;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ien <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_ien <= i_writedata[CTRL_IEN];
    end
  end
  assign w_ien = r_ien;
  assign o_irq = r_ien && (r_done || r_aborted);
`else
  assign w_ien = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (i_address)
      CSR_CTRL: begin
        w_rdata[STAT_BUSY]  = i_busy;
        w_rdata[STAT_DONE]  = r_done;
        w_rdata[STAT_MIS]   = r_mis;
        w_rdata[STAT_RANGE] = r_range;
        w_rdata[STAT_ABRT]  = r_aborted;
        w_rdata[CTRL_IEN]   = w_ien;
      end
      CSR_BASE:   w_rdata = r_base;
      CSR_LEN:    w_rdata = r_len;
      CSR_PAT:    w_rdata = r_pat;
      CSR_ERRCNT: w_rdata = r_errcnt;
      CSR_FIRST:  w_rdata = r_first;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_base     <= '0;
      r_len      <= '0;
      r_pat      <= '0;
      r_errcnt   <= '0;
      r_first    <= '0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_range    <= 1'b0;
      r_aborted  <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_cfg_wr && i_address == CSR_BASE) r_base <= i_writedata;
      if (w_cfg_wr && i_address == CSR_LEN)  r_len  <= i_writedata;
      if (w_cfg_wr && i_address == CSR_PAT)  r_pat  <= i_writedata;

      if (i_start_ok) begin
        r_errcnt  <= '0;
        r_first   <= '0;
        r_done    <= 1'b0;
        r_mis     <= 1'b0;
        r_range   <= 1'b0;
        r_aborted <= 1'b0;
      end else if (w_clear) begin
        r_done    <= 1'b0;
        r_mis     <= 1'b0;
        r_range   <= 1'b0;
        r_aborted <= 1'b0;
      end

      // set events follow the clear so an empty/bad start reports at once
      if (i_set_done)  r_done    <= 1'b1;
      if (i_set_range) r_range   <= 1'b1;
      if (i_set_abort) r_aborted <= 1'b1;

      if (i_mis) begin
        if (r_errcnt != 32'hFFFF_FFFF) r_errcnt <= r_errcnt + 32'd1;
        if (!r_mis) begin
          r_mis   <= 1'b1;
          r_first <= {{(32-ADDR_W){1'b0}}, i_mis_addr};
        end
      end

      r_readdata <= i_read ? w_rdata : '0;
    end
  end

endmodule

// File: rtl/onchip_mem_fill_engine.sv
// Fills or checks a word range of on-chip RAM port 2 with a fixed or
// incrementing pattern. Ports: clk, reset_n, bus (CSR slave + RAM master),
// irq only when ONCHIP_FILL_IRQ_EN is defined.
module onchip_mem_fill_engine
  import onchip_fill_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 102400
) (
  input logic clk,
  input logic reset_n,
  onchip_mem_fill_engine_if.slave bus
`ifdef ONCHIP_FILL_IRQ_EN
  ,
  output logic irq
`endif
);

  state_t            r_state;
  state_t            w_nstate;
  logic [31:0]       r_idx;
  logic              r_incr;
  logic              r_cmp_vld;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;

  logic              w_start;
  logic              w_abort;
  logic              w_mode_in;
  logic              w_incr_in;
  logic [31:0]       w_base;
  logic [31:0]       w_len;
  logic [31:0]       w_pat;
  logic [31:0]       w_rdata;
  logic              w_busy;
  logic [32:0]       w_end;
  logic              w_range_bad;
  logic              w_len_zero;
  logic              w_start_ok;
  logic              w_launch;
  logic              w_last;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_addr;
  logic              w_cs;
  logic              w_we;
  logic              w_fin;
  logic              w_set_abort;
  logic              w_set_done;
  logic              w_set_range;
  logic              w_mis;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_end       = {1'b0, w_base} + {1'b0, w_len};
  assign w_range_bad = w_end > 33'(DEPTH);
  assign w_len_zero  = (w_len == 32'd0);
  assign w_start_ok  = w_start && !w_busy;
  assign w_launch    = w_start_ok && !w_len_zero && !w_range_bad;
  assign w_last      = (r_idx == w_len - 32'd1);
  assign w_data      = DATA_W'(w_pat + (r_incr ? r_idx : 32'd0));
  assign w_addr      = ADDR_W'(w_base) + ADDR_W'(r_idx);

  // rejected starts complete immediately without touching the RAM
  assign w_set_done  = w_fin
                     || (w_start_ok && (w_len_zero || w_range_bad));
  assign w_set_range = w_start_ok && !w_len_zero && w_range_bad;

  // the compare for the word read last cycle; dropped on ABORT
  assign w_mis = r_cmp_vld && !w_abort
               && (bus.mem_readdata != r_cmp_exp);

  always_comb begin
    w_nstate    = r_state;
    w_cs        = 1'b0;
    w_we        = 1'b0;
    w_fin       = 1'b0;
    w_set_abort = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_nstate = (w_mode_in == MODE_CHECK) ? ST_CHECK : ST_FILL;
        end
      end
      ST_FILL: begin
        w_cs = 1'b1;
        w_we = 1'b1;
        if (w_abort) begin
          w_nstate    = ST_IDLE;
          w_set_abort = 1'b1;
        end else if (w_last) begin
          w_nstate = ST_IDLE;
          w_fin    = 1'b1;
        end
      end
      ST_CHECK: begin
        w_cs = 1'b1;
        if (w_abort) begin
          w_nstate    = ST_IDLE;
          w_set_abort = 1'b1;
        end else if (w_last) begin
          w_nstate = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_nstate = ST_IDLE;
        if (w_abort) w_set_abort = 1'b1;
        else         w_fin       = 1'b1;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_incr     <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_launch) begin
        r_idx  <= '0;
        r_incr <= w_incr_in;
      end else if (w_cs) begin
        r_idx <= r_idx + 32'd1;
      end
      r_cmp_vld <= w_cs && !w_we && !w_abort;
      if (w_cs && !w_we) begin
        r_cmp_exp  <= w_data;
        r_cmp_addr <= w_addr;
      end
    end
  end

  assign bus.mem_chipselect = w_cs;
  assign bus.mem_write      = w_we;
  assign bus.mem_address    = w_cs ? w_addr : '0;
  assign bus.mem_writedata  = w_we ? w_data : '0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.csr_readdata   = w_rdata;

  onchip_fill_csr #(
    .ADDR_W (ADDR_W)
  ) u_csr (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_address   (bus.csr_address),
    .i_read      (bus.csr_read),
    .i_write     (bus.csr_write),
    .i_writedata (bus.csr_writedata),
    .o_readdata  (w_rdata),
    .i_busy      (w_busy),
    .i_start_ok  (w_start_ok),
    .i_set_done  (w_set_done),
    .i_set_range (w_set_range),
    .i_set_abort (w_set_abort),
    .i_mis       (w_mis),
    .i_mis_addr  (r_cmp_addr),
    .o_start     (w_start),
    .o_abort     (w_abort),
    .o_mode      (w_mode_in),
    .o_incr      (w_incr_in),
    .o_base      (w_base),
    .o_len       (w_len),
    .o_pat       (w_pat)
`ifdef ONCHIP_FILL_IRQ_EN
    ,
    .o_irq       (irq)
`endif
  );

endmodule

// File: tb/tb_onchip_mem_fill_engine.sv
// Scoreboard bench for onchip_mem_fill_engine with a behavioural RAM.
// Expected accesses and CSR reads are queued at issue, checked by a monitor.
module tb_onchip_mem_fill_engine;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 102400;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_fill_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef ONCHIP_FILL_IRQ_EN
  logic irq;
`endif

  onchip_mem_fill_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef ONCHIP_FILL_IRQ_EN
    , .irq(irq)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: port 2 is the DUT, port 1 is the bench
  logic [31:0] ram [DEPTH];
  logic p1_we = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [31:0] p1_data = '0;
  always @(posedge clk) begin
    if (p1_we) ram[p1_addr] <= p1_data;
    if (bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  typedef struct {
    int cyc;
    bit wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
  } acc_t;
  typedef struct {
    string name;
    logic [31:0] val;
  } rd_t;
  acc_t acc_q[$];
  rd_t rd_q[$];
  bit rd_pend = 1'b0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic bad(string n, logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h expected nothing", n, act);
  endtask

  always @(posedge clk) rd_pend <= bus.csr_read;

  always @(negedge clk) begin
    acc_t a;
    rd_t r;
    if (rd_pend) begin
      if (rd_q.size() == 0) bad("csr_rd_unexpected", bus.csr_readdata);
      else begin
        r = rd_q.pop_front();
        chk(r.name, bus.csr_readdata, r.val);
      end
    end
    if (bus.mem_chipselect) begin
      if (acc_q.size() == 0) bad("mem_unexpected", 32'(bus.mem_address));
      else begin
        a = acc_q.pop_front();
        chk("acc_cycle", cyc, a.cyc);
        chk("acc_write", 32'(bus.mem_write), 32'(a.wr));
        chk("acc_addr", 32'(bus.mem_address), 32'(a.addr));
        if (a.wr) chk("acc_data", bus.mem_writedata, a.data);
        chk("acc_be", 32'(bus.mem_byteenable), 32'hF);
      end
    end
  end

  logic [31:0] m_base, m_len, m_pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    bus.csr_address = a;
    bus.csr_writedata = d;
    bus.csr_write = 1'b1;
    tick();
    bus.csr_write = 1'b0;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] e, string n);
    bus.csr_address = a;
    bus.csr_read = 1'b1;
    rd_q.push_back(rd_t'{name: n, val: e});
    tick();
    bus.csr_read = 1'b0;
  endtask

  task automatic setcfg();
    wr(3'd1, m_base);
    wr(3'd2, m_len);
    wr(3'd3, m_pat);
  endtask

  function automatic logic [31:0] pword(logic [31:0] p, bit inc, int i);
    return p + (inc ? 32'(i) : 32'd0);
  endfunction

  // CTRL status seen in cycle k for an op whose START was in cycle t
  function automatic logic [31:0] status(int k, int t, int n, bit mode,
                                         bit valid, bit rng, int fb);
    logic [31:0] s;
    int e;
    s = '0;
    if (!valid) begin
      s[1] = (k > t);
      s[3] = rng;
      return s;
    end
    e = t + n + int'(mode);
    s[0] = (k > t) && (k <= e);
    s[1] = (k > e);
    s[2] = (fb >= 0) && (k >= t + fb + 3);
    return s;
  endfunction

  task automatic start(bit mode, bit inc, int nacc, output int t);
    t = cyc;
    for (int i = 0; i < nacc; i++)
      acc_q.push_back(acc_t'{cyc: t + 1 + i, wr: !mode,
        addr: ADDR_W'(m_base + 32'(i)), data: pword(m_pat, inc, i)});
    wr(3'd0, {29'b0, inc, mode, 1'b1});
  endtask

  task automatic do_op(bit mode, bit inc, bit poll, bit meddle);
    int t, n, nbad, fb;
    logic [31:0] fba;
    n = int'(m_len);
    nbad = 0;
    fb = -1;
    fba = '0;
    if (mode)
      for (int i = 0; i < n; i++)
        if (ram[m_base + 32'(i)] !== pword(m_pat, inc, i)) begin
          if (fb < 0) begin
            fb = i;
            fba = m_base + 32'(i);
          end
          nbad++;
        end
    start(mode, inc, n, t);
    if (poll) begin
      for (int j = 0; j < n + 2 + int'(mode); j++)
        rd(3'd0, status(cyc, t, n, mode, 1'b1, 1'b0, fb), "ctrl_poll");
    end else begin
      if (meddle && n >= 3) begin
        wr(3'd1, $urandom);
        wr(3'd0, 32'h3);
      end
      while (cyc <= t + n + 3) tick();
    end
    chk("acc_left", acc_q.size(), 0);
    rd(3'd4, nbad, "err_count");
    rd(3'd5, fba, "first_err_addr");
    rd(3'd0, {29'b0, fb >= 0, 2'b10}, "ctrl_done");
  endtask

  task automatic corrupt(logic [31:0] a, logic [31:0] x);
    p1_addr = ADDR_W'(a);
    p1_data = ram[a] ^ x;
    p1_we = 1'b1;
    tick();
    p1_we = 1'b0;
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_cs"}, 32'(bus.mem_chipselect), 0);
    chk({n, "_we"}, 32'(bus.mem_write), 0);
    chk({n, "_addr"}, 32'(bus.mem_address), 0);
    chk({n, "_wdata"}, bus.mem_writedata, 0);
    chk({n, "_rdata"}, bus.csr_readdata, 0);
    chk({n, "_be"}, 32'(bus.mem_byteenable), 32'hF);
    chk({n, "_clken"}, 32'(bus.mem_clken), 1);
`ifdef ONCHIP_FILL_IRQ_EN
    chk({n, "_irq"}, 32'(irq), 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.csr_address = '0;
    bus.csr_read = 1'b0;
    bus.csr_write = 1'b0;
    bus.csr_writedata = '0;
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_reset_outs("reset");
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, "csr_reset");

    // directed fill then check
    m_base = 32'h10; m_len = 4; m_pat = 32'hA5A5_0000;
    setcfg();
    rd(3'd2, 32'd4, "len_readback");
    do_op(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("fill_word", ram[32'h10 + i], 32'hA5A5_0000 + 32'(i));
`ifdef ONCHIP_FILL_IRQ_EN
    wr(3'd0, 32'h20);
    rd(3'd0, 32'h22, "ctrl_ien");
    chk("irq_on", 32'(irq), 1);
    wr(3'd6, 32'h0);
    chk("irq_cleared", 32'(irq), 0);
`else
    wr(3'd0, 32'h20);
    rd(3'd0, 32'h2, "ctrl_ien_absent");
`endif
    wr(3'd0, 32'h0);
    wr(3'd6, 32'h0);
    rd(3'd0, 32'h0, "ctrl_after_clear");
    do_op(1'b1, 1'b1, 1'b1, 1'b0);
    corrupt(32'h12, 32'h0000_0100);
    do_op(1'b1, 1'b1, 1'b1, 1'b0);
    rd(3'd4, 32'd1, "dir_errcnt");
    rd(3'd5, 32'h12, "dir_first");

    // empty and out-of-range starts
    m_len = 0;
    setcfg();
    start(1'b0, 1'b0, 0, t);
    for (int j = 0; j < 3; j++)
      rd(3'd0, status(cyc, t, 0, 1'b0, 1'b0, 1'b0, -1), "ctrl_len0");
    m_base = 102398; m_len = 4;
    setcfg();
    start(1'b0, 1'b0, 0, t);
    for (int j = 0; j < 3; j++)
      rd(3'd0, status(cyc, t, 4, 1'b0, 1'b0, 1'b1, -1), "ctrl_range");

    // abort on the 10th write of a 100-word fill
    m_base = 32'h100; m_len = 100; m_pat = 32'h1234_0000;
    setcfg();
    start(1'b0, 1'b1, 10, t);
    while (cyc < t + 10) tick();
    wr(3'd0, 32'h9);
    tick();
    tick();
    chk("abort_acc_left", acc_q.size(), 0);
    rd(3'd0, 32'h10, "ctrl_aborted");
    chk("abort_word9", ram[32'h109], 32'h1234_0009);
    m_len = 5;
    setcfg();
    do_op(1'b0, 1'b0, 1'b1, 1'b0);

    // randomized fill / corrupt / check rounds
    for (int it = 0; it < 8; it++) begin
      bit inc;
      m_base = $urandom_range(0, DEPTH - 64);
      m_len = $urandom_range(1, 24);
      m_pat = $urandom;
      inc = 1'($urandom);
      if (it == 0) begin
        m_pat = 32'hFFFF_FFFE;
        inc = 1'b1;
        m_len = 6;
      end
      setcfg();
      do_op(1'b0, inc, 1'b0, 1'b1);
      for (int c = 0; c < int'($urandom_range(0, 3)); c++)
        corrupt(m_base + $urandom_range(0, int'(m_len) - 1),
                32'h1 << $urandom_range(0, 31));
      do_op(1'b1, inc, 1'(it), 1'b0);
    end

    // reset in the middle of a check
    m_base = 32'h200; m_len = 50; m_pat = 32'h0;
    setcfg();
    start(1'b1, 1'b0, 50, t);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    acc_q.delete();
    @(negedge clk);
    chk_reset_outs("midreset");
    tick();
    rd(3'd0, 32'h0, "ctrl_after_reset");
    rd(3'd2, 32'h0, "len_after_reset");
    m_base = 32'h300; m_len = 3; m_pat = 32'hCAFE_0000;
    setcfg();
    do_op(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("final_acc_left", acc_q.size(), 0);
    chk("final_rd_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
